pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised, elastic pipeline stage register replacing the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries an opaque WIDTH-bit payload under a valid/ready handshake and holds up to two beats in a skid buffer. This lets a stall propagate one stage per cycle with a fully registered `in_ready`, with no combinational path from downstream stall logic. A synchronous flush squashes all held beats for branch/jump recovery.

## Interface
- WIDTH, 32: payload width in bits; the caller packs control and data fields.
- RST_VAL, '0: payload register value after reset.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held beats at next edge.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; driven directly from a flop.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  beat available to downstream.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  WIDTH  downstream payload; driven directly from the main register.
- count  out  2  beats held (0..2).

## Operation
- Storage: main register `main_q` (drives `out_data`) and skid register `skid_q`. State is one of EMPTY, ONE, FULL.
- Outputs: `out_valid` = (state != EMPTY); `in_ready` = (state != FULL); `count` = 0, 1 or 2 per state.
- Accept in = in_valid & in_ready; accept out = out_valid & out_ready.
- EMPTY:
  - accept in -> ONE, `main_q` <= in_data.
  - otherwise hold.
- ONE:
  - in & out -> ONE, `main_q` <= in_data.
  - in only -> FULL, `skid_q` <= in_data.
  - out only -> EMPTY.
  - neither -> hold.
- FULL (no input acceptance):
  - out -> ONE, `main_q` <= `skid_q`.
  - otherwise hold.
- Ordering: beats leave in arrival order; no beat is duplicated or dropped except by flush or reset.
- Flush: next state EMPTY regardless of the handshakes.
  - An input accepted in the flush cycle is discarded.
  - An output accepted in the flush cycle counts as delivered; the downstream completed it.
  - Data registers are not cleared by flush.
- Priority: RST > flush > handshake.

## Timing
- Reset: state EMPTY, `main_q` = `skid_q` = RST_VAL.
  - Outputs after reset: out_valid=0, in_ready=1, count=0, out_data=RST_VAL.
- Reset mid-operation behaves identically to flush, and additionally loads RST_VAL into both data registers.
- Latency: a beat accepted at edge N is presented on `out_data` with out_valid=1 from edge N+1.
- Throughput: one beat per cycle sustained while out_ready=1.
- Backpressure: when out_ready drops, in_ready falls at most one edge later. The one beat accepted in the meantime lands in `skid_q`.
- Restart from FULL: on out_ready=1, the next edge moves `skid_q` to `main_q`; in_ready rises at that same edge.
- in_valid and in_data may change only after a completed accept or while in_valid=0. The stage does not check this; upstream must comply.
- Simultaneous flush and out_ready in FULL: the stage goes to EMPTY; the skid beat is squashed.

## Structure
- Shared package `pipe_pkg`: enum `skid_state_t` {SKID_EMPTY, SKID_ONE, SKID_FULL}; helper constant `PIPE_CNT_W` = 2.
- Companion parametrised interface `pipe_stage_if #(WIDTH)` with modports `stage`, `up`, `down` and `tb`.
- Existing per-stage latches are replaced by an instance of this block plus a packed struct per stage.
  - The struct (e.g. `ex_mem_t` with regdst, dREN, dWEN, dmemstore, regwr, memtoreg, halt, portO, lui, pcp4, wsel, op) lives in `pipe_pkg`.
  - WIDTH is set to `$bits(ex_mem_t)`.
- No sub-module: state and registers fit in one `always_ff` block plus one next-state `always_comb` block.

## Test plan
- Reset, then idle: out_valid=0, in_ready=1, count=0, out_data=RST_VAL.
- Streaming: send 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1. Outputs appear one cycle later in order; count stays 1; in_ready stays 1.
- Skid fill: out_ready=0 while sending 0xA, 0xB, 0xC.
  - 0xA is held in `main_q`; 0xB goes to skid; count=2; in_ready=0; 0xC is held upstream.
  - Raise out_ready: outputs are 0xA, 0xB, 0xC with no gaps.
- Flush in FULL with out_ready=1: 0xA is delivered; 0xB is squashed; next cycle out_valid=0, count=0, in_ready=1.
- Flush in EMPTY with in_valid=1, data 0x55: the beat is dropped; out_valid stays 0 the next cycle.
- RST asserted in FULL with flush=0: next edge gives count=0, out_data=RST_VAL, in_ready=1. A random stall/flush scoreboard run of 10k cycles shows no loss or duplication outside flush or reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the elastic pipeline stage and its users.
//   skid_state_t : occupancy state of pipe_skid_stage (empty / one beat / two beats)
//   PIPE_CNT_W   : width of the stage occupancy count output
//   ex_mem_t     : EX/MEM payload, carried opaquely as WIDTH = $bits(ex_mem_t)
package pipe_pkg;

  localparam int unsigned PIPE_CNT_W = 2;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Field names kept as in the original EX/MEM latch so existing stage logic maps 1:1.
  typedef struct packed {
    logic        regdst;
    logic        dREN;
    logic        dWEN;
    logic [31:0] dmemstore;
    logic        regwr;
    logic        memtoreg;
    logic        halt;
    logic [31:0] portO;
    logic [31:0] lui;
    logic [31:0] pcp4;
    logic [4:0]  wsel;
    logic [5:0]  op;
  } ex_mem_t;

endpackage

// File: rtl/pipe_stage_if.sv
// pipe_stage_if: bundle of the handshake signals around one pipe_skid_stage.
//   flush              : squash request from hazard/branch logic
//   in_valid/in_data   : upstream beat, in_ready back-pressure
//   out_valid/out_data : downstream beat, out_ready acceptance
//   count              : beats held by the stage
// Modports: stage (the block itself), up (producer), down (consumer), tb (driver+observer).
interface pipe_stage_if #(
  parameter int unsigned WIDTH = 32
);

  logic                            flush;
  logic                            in_valid;
  logic                            in_ready;
  logic [WIDTH-1:0]                in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [WIDTH-1:0]                out_data;
  logic [pipe_pkg::PIPE_CNT_W-1:0] count;

  modport stage (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport up (
    output flush, in_valid, in_data,
    input  in_ready
  );

  modport down (
    input  out_valid, out_data, count,
    output out_ready
  );

  modport tb (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic two-entry pipeline register (main + skid) with valid/ready
// handshake and synchronous flush. in_ready, out_valid and count come straight from flops,
// so downstream stall logic never reaches upstream combinationally.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   flush               : drop all held beats at the next edge (data registers keep contents)
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload (from main register)
//   count               : beats held, 0..2
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [PIPE_CNT_W-1:0] count
);

  skid_state_t           r_state;
  logic [WIDTH-1:0]      r_main;
  logic [WIDTH-1:0]      r_skid;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [PIPE_CNT_W-1:0] r_count;

  skid_state_t           w_state_d;
  logic [WIDTH-1:0]      w_main_d;
  logic [WIDTH-1:0]      w_skid_d;
  logic                  w_acc_in;
  logic                  w_acc_out;

  assign w_acc_in  = in_valid & r_in_ready;
  assign w_acc_out = r_out_valid & out_ready;

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    unique case (r_state)
      SKID_EMPTY: begin
        if (w_acc_in) begin
          w_state_d = SKID_ONE;
          w_main_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (w_acc_in && w_acc_out) begin
          w_main_d = in_data;
        end else if (w_acc_in) begin
          w_state_d = SKID_FULL;
          w_skid_d  = in_data;
        end else if (w_acc_out) begin
          w_state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only the drain direction can fire.
        if (w_acc_out) begin
          w_state_d = SKID_ONE;
          w_main_d  = r_skid;
        end
      end
      default: begin
        w_state_d = SKID_EMPTY;
      end
    endcase
    // Flush squashes occupancy only; stale data stays but is never presented as valid.
    if (flush) begin
      w_state_d = SKID_EMPTY;
      w_main_d  = r_main;
      w_skid_d  = r_skid;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= SKID_EMPTY;
      r_main      <= RST_VAL;
      r_skid      <= RST_VAL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_main      <= w_main_d;
      r_skid      <= w_skid_d;
      // Handshake outputs are registered copies decoded from the next state.
      r_in_ready  <= (w_state_d != SKID_FULL);
      r_out_valid <= (w_state_d != SKID_EMPTY);
      r_count     <= (w_state_d == SKID_FULL) ? PIPE_CNT_W'(2) :
                     (w_state_d == SKID_ONE)  ? PIPE_CNT_W'(1) : PIPE_CNT_W'(0);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random stimulus for pipe_skid_stage. Accepted input beats
// are pushed into an expected queue; a negedge monitor pops and compares every delivered beat.
module tb_pipe_skid_stage;

  localparam int unsigned      W  = 32;
  localparam logic [W-1:0]     RV = 32'hDEAD_BEEF;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pipe_stage_if #(.WIDTH(W)) u_if ();

  pipe_skid_stage #(
    .WIDTH  (W),
    .RST_VAL(RV)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (u_if.flush),
    .in_valid (u_if.in_valid),
    .in_ready (u_if.in_ready),
    .in_data  (u_if.in_data),
    .out_valid(u_if.out_valid),
    .out_ready(u_if.out_ready),
    .out_data (u_if.out_data),
    .count    (u_if.count)
  );

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a beat with out_valid & out_ready at negedge is delivered at the next edge.
  always @(negedge CLK) begin
    if (!RST && u_if.out_valid && u_if.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %0h want no beat at %0t", u_if.out_data, $time);
      end else begin
        chk("sb_data", u_if.out_data, exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    u_if.in_valid  = v;
    u_if.in_data   = d;
    u_if.out_ready = r;
    u_if.flush     = f;
    #1;
    if (v && u_if.in_ready && !f && !RST) exp_q.push_back(d);
    @(negedge CLK);
    #2;
    // After the monitor has taken any beat delivered this cycle, drop whatever remains held.
    if (f || RST) exp_q.delete();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string name, input logic ov, input logic ir,
                           input logic [1:0] cnt);
    chk({name, "_out_valid"}, 32'(u_if.out_valid), 32'(ov));
    chk({name, "_in_ready"}, 32'(u_if.in_ready), 32'(ir));
    chk({name, "_count"}, 32'(u_if.count), 32'(cnt));
  endtask

  logic [W-1:0] seq;
  logic         pv;
  logic         acc;
  logic         rr;
  logic         ff;

  initial begin
    RST = 1'b1;
    u_if.flush = 1'b0; u_if.in_valid = 1'b0; u_if.in_data = '0; u_if.out_ready = 1'b0;
    @(posedge CLK);
    #1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    RST = 1'b0;
    chk_state("reset", 0, 1, 0);
    chk("reset_data", u_if.out_data, RV);
    cyc(0, 0, 1, 0);
    chk_state("idle", 0, 1, 0);

    // Streaming
    cyc(1, 32'h11, 1, 0);
    chk_state("s1", 1, 1, 1);
    chk("s1_data", u_if.out_data, 32'h11);
    cyc(1, 32'h22, 1, 0);
    chk_state("s2", 1, 1, 1);
    chk("s2_data", u_if.out_data, 32'h22);
    cyc(1, 32'h33, 1, 0);
    chk_state("s3", 1, 1, 1);
    cyc(0, 0, 1, 0);
    chk_state("s_drain", 0, 1, 0);

    // Skid fill and restart
    cyc(1, 32'hA, 0, 0);
    chk_state("k1", 1, 1, 1);
    cyc(1, 32'hB, 0, 0);
    chk_state("k2", 1, 0, 2);
    chk("k2_data", u_if.out_data, 32'hA);
    cyc(1, 32'hC, 0, 0);
    chk_state("k3", 1, 0, 2);
    cyc(1, 32'hC, 1, 0);
    chk_state("k4", 1, 1, 1);
    chk("k4_data", u_if.out_data, 32'hB);
    cyc(1, 32'hC, 1, 0);
    chk_state("k5", 1, 1, 1);
    chk("k5_data", u_if.out_data, 32'hC);
    cyc(0, 0, 1, 0);
    chk_state("k_drain", 0, 1, 0);

    // Flush in FULL with out_ready: A delivered, B squashed
    cyc(1, 32'hA, 0, 0);
    cyc(1, 32'hB, 0, 0);
    chk_state("ff_pre", 1, 0, 2);
    cyc(0, 0, 1, 1);
    chk_state("ff_post", 0, 1, 0);

    // Flush in EMPTY drops the incoming beat
    cyc(1, 32'h55, 1, 1);
    chk_state("fe_post", 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk_state("fe_idle", 0, 1, 0);

    // Reset while FULL
    cyc(1, 32'h1, 0, 0);
    cyc(1, 32'h2, 0, 0);
    chk_state("rf_pre", 1, 0, 2);
    RST = 1'b1;
    cyc(0, 0, 0, 0);
    RST = 1'b0;
    chk_state("rf_post", 0, 1, 0);
    chk("rf_data", u_if.out_data, RV);

    // Random stall/flush run; upstream holds a pending beat until it is taken.
    seq = 32'h1000;
    pv  = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!pv && ($urandom_range(0, 3) != 0)) begin
        pv  = 1'b1;
        seq = seq + 1;
      end
      rr  = ($urandom_range(0, 2) != 0);
      ff  = ($urandom_range(0, 31) == 0);
      acc = pv && u_if.in_ready;
      cyc(pv, seq, rr, ff);
      if (acc) pv = 1'b0;
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk_state("final", 0, 1, 0);
    chk("final_sb_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
